md_sched: RTL and testbench
===========================

# md_sched

Multiply/divide scheduler for the EXE stage: owns the HI/LO register pair and sequences the multi-cycle multiply/divide unit started by mult/multu/div/divu. It latches operands at issue, holds `busy` for the architectural latency, commits HI/LO at completion, and services mthi/mtlo writes. It also raises a stall request so that md-class instructions waiting in decode do not issue while an operation is in flight.

## Interface
- `MULT_CYCLES`, 5, busy duration of mult/multu in cycles (≥1)
- `DIV_CYCLES`, 10, busy duration of div/divu in cycles (≥1)

- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle issue pulse for mult/multu/div/divu
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with `start`
- `we`  in  1  mthi/mtlo write strobe
- `hilo`  in  1  1 selects HI, 0 selects LO for `we`
- `d1`  in  32  operand A (rs); dividend for div
- `d2`  in  32  operand B (rt); divisor for div
- `d_is_md`  in  1  decode stage holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- `busy`  out  1  operation in flight
- `stall`  out  1  stall request to hazard unit
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- FSM states: IDLE, RUN. Reset: IDLE, counter 0, `busy`=0, `hi`=`lo`=0, pending result 0.
- IDLE + `start`: latch op result into a 64-bit pending register, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
- RUN: counter decrements every edge; on the edge where counter==1, write pending {HI,LO}, return to IDLE.
- `busy` = (state==RUN); combinational, no dependence on `start`.
- `stall` = `d_is_md` & (`start` | `busy`).
- Arithmetic: mult = signed 32×32→64, multu unsigned; HI=upper, LO=lower. div/divu: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes dividend's sign. 0x80000000 / 0xFFFFFFFF (signed) → LO=0x80000000, HI=0.
- Divide by zero: op runs full DIV_CYCLES, `busy` behaves normally, HI/LO left unchanged at completion.
- `we` in IDLE with no `start`: writes `d1` to HI or LO at the edge; visible next cycle.
- `we` and `start` in same cycle: `start` wins, `we` dropped.
- `start` or `we` while `busy`: ignored (hazard unit guarantees absence; assertion in bench).
- Async `rst` in RUN: immediately IDLE, pending result discarded, HI/LO cleared.

## Timing
- `start` sampled at edge T; `busy` high from T to T+N (N cycles observed), low after T+N.
- HI/LO update on edge T+N; readable by mfhi/mflo in the cycle `busy` first reads 0.
- `stall` is combinational and asserted in the `start` cycle itself, covering a back-to-back md instruction in decode.
- Back-to-back issue: a new `start` is accepted in the first cycle with `busy`=0.
- `we` has 1-cycle latency; `hi`/`lo` are direct register outputs.

## Structure
- Shared `define.v` gets: md op codes (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and default latency constants MD_MULT_CYCLES, MD_DIV_CYCLES; EXE stage uses the same op codes to drive `op`.
- One sub-module natural: `md_calc`, purely combinational, op/d1/d2 → 64-bit {hi,lo} plus div-by-zero flag; scheduler keeps FSM, counter, registers.
- Counter width sized by max(MULT_CYCLES, DIV_CYCLES).

## Test plan
- Reset then idle: `rst` low mid-cycle → `busy`=0, `hi`=`lo`=0 immediately, stays so with no stimulus.
- mult d1=0xFFFFFFFE, d2=3 → `busy` high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div d1=0xFFFFFFF9 (−7), d2=2 → `busy` 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 → busy 10 cycles, HI/LO unchanged.
- `start` with `d_is_md`=1 → `stall`=1 in issue cycle and all busy cycles, 0 the cycle after completion; second `start` that cycle accepted.
- mthi d1=0x12345678 then mtlo d1=0x9ABCDEF0 in IDLE → values visible next cycle; `we` together with `start` → HI/LO ignore `we`.
- `rst` asserted at cycle 3 of a div → `busy` drops immediately, HI/LO=0, no later commit after release.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op codes, default
// latencies and the FSM state type.
package md_sched_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    function automatic int md_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: produces {hi, lo} for the selected
// op and flags a zero divisor so the scheduler can suppress the commit.
module md_calc
    import md_sched_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    output logic [63:0] res,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic        d2_zero;
    logic        div_ovf;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod_s  = {{32{d1[31]}}, d1} * {{32{d2[31]}}, d2};
    assign prod_u  = {32'd0, d1} * {32'd0, d2};

    // A substitute divisor keeps the dividers free of divide-by-zero.
    assign d2_zero = (d2 == 32'd0);
    assign divisor = d2_zero ? 32'd1 : d2;
    assign div_ovf = (d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF);

    assign quo_s   = $unsigned($signed(d1) / $signed(divisor));
    assign rem_s   = $unsigned($signed(d1) % $signed(divisor));
    assign quo_u   = d1 / divisor;
    assign rem_u   = d1 % divisor;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        res      = 64'd0;
        div_zero = 1'b0;
        case (md_op_e'(op))
            MD_MULT:  res = prod_s;
            MD_MULTU: res = prod_u;
            MD_DIV: begin
                div_zero = d2_zero;
                if (div_ovf) res = {32'd0, 32'h8000_0000};
                else         res = {rem_s, quo_s};
            end
            MD_DIVU: begin
                div_zero = d2_zero;
                res      = {rem_u, quo_u};
            end
            default: res = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, sequences multi-cycle md ops and
// requests a decode stall while an md op is issuing or in flight.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic        we,
    input  logic        hilo,
    input  logic [31:0] d1,
    input  logic [31:0] d2,
    input  logic        d_is_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    md_state_e   state;
    logic [CW-1:0] count;
    logic [63:0] pending;
    logic        pending_dz;
    logic [63:0] calc_res;
    logic        calc_dz;
    logic        is_div;

    md_calc u_calc (
        .op       (op),
        .d1       (d1),
        .d2       (d2),
        .res      (calc_res),
        .div_zero (calc_dz)
    );

    assign is_div = (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    assign busy   = (state == ST_RUN);
    assign stall  = d_is_md & (start | busy);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            pending    <= 64'd0;
            pending_dz <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pending    <= calc_res;
                        pending_dz <= calc_dz;
                        count      <= is_div ? DIV_CNT : MULT_CNT;
                        state      <= ST_RUN;
                    end else if (we) begin
                        if (hilo) hi <= d1;
                        else      lo <= d1;
                    end
                end
                ST_RUN: begin
                    count <= count - CNT_ONE;
                    if (count == CNT_ONE) begin
                        // A zero divisor runs the full latency but leaves HI/LO alone.
                        if (!pending_dz) {hi, lo} <= pending;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Scoreboard bench for md_sched: stimulus pushes expected {hi, lo, latency},
// a negedge monitor pops and compares when busy falls.
module tb_md_sched;
    import md_sched_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic        we;
    logic        hilo;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        d_is_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    int   busy_cnt  = 0;
    logic prev_busy = 1'b0;

    md_sched dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .we      (we),
        .hilo    (hilo),
        .d1      (d1),
        .d2      (d2),
        .d_is_md (d_is_md),
        .busy    (busy),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: count busy cycles, compare on the falling edge of busy.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy === 1'b1) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: completion with no expected entry, hi=%h lo=%h", hi, lo);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_cycles"}, 64'(busy_cnt), 64'(e.cycles));
                    check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                end
                busy_cnt = 0;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    // The hazard unit never issues into a busy unit; flag any bench that does.
    always @(negedge clk) begin
        if (rst && busy === 1'b1 && (start || we))
            $error("start/we driven while busy");
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_idle_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic issue(input string name, input md_op_e o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh,
                         input logic [31:0] el, input int cyc);
        exp_t e;
        e.name = name; e.hi = eh; e.lo = el; e.cycles = cyc;
        op = o; d1 = a; d2 = b; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(name);
    endtask

    task automatic write_reg(input logic sel, input logic [31:0] v);
        we = 1'b1; hilo = sel; d1 = v;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        exp_t e;
        int n;
        rst = 1'b1; start = 1'b0; op = MD_MULT; we = 1'b0; hilo = 1'b0;
        d1 = '0; d2 = '0; d_is_md = 1'b0;

        // Asynchronous reset mid-cycle, then idle with no stimulus.
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_hilo", {hi, lo}, 64'(0));

        // Multiply and divide with hand-computed results.
        issue("mult",     MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue("multu",    MD_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5);
        issue("div_neg",  MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("divu_z",   MD_DIVU,  32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue("div_ovf",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        issue("div_nden", MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue("divu_big", MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 10);

        // Stall across issue and busy cycles, then back-to-back issue.
        d_is_md = 1'b1;
        op = MD_MULT; d1 = 32'd6; d2 = 32'd7; start = 1'b1;
        e.name = "stall_mult"; e.hi = 32'd0; e.lo = 32'd42; e.cycles = 5;
        sb.push_back(e);
        #1;
        check("stall_issue", 64'(stall), 64'(1));
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            check("stall_busy", 64'(stall), 64'(1));
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_busy_cycles", 64'(n), 64'(5));
        check("stall_after", 64'(stall), 64'(0));
        op = MD_DIVU; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        e.name = "b2b_divu"; e.hi = 32'd2; e.lo = 32'd14; e.cycles = 10;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_accepted", 64'(busy), 64'(1));
        wait_idle("b2b_divu");
        d_is_md = 1'b0;
        #1;
        check("stall_idle", 64'(stall), 64'(0));

        // mthi / mtlo in IDLE, one-cycle latency.
        write_reg(1'b1, 32'h1234_5678);
        check("mthi", 64'(hi), 64'(32'h1234_5678));
        write_reg(1'b0, 32'h9ABC_DEF0);
        check("mtlo", 64'(lo), 64'(32'h9ABC_DEF0));
        check("mtlo_hi_kept", 64'(hi), 64'(32'h1234_5678));

        // we together with start: start wins, we dropped.
        we = 1'b1; hilo = 1'b1; op = MD_MULT; d1 = 32'd2; d2 = 32'd3; start = 1'b1;
        e.name = "we_start"; e.hi = 32'd0; e.lo = 32'd6; e.cycles = 5;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; we = 1'b0;
        check("we_dropped", 64'(hi), 64'(32'h1234_5678));
        wait_idle("we_start");

        // Async reset in the third busy cycle of a divide.
        write_reg(1'b1, 32'hDEAD_BEEF);
        check("mthi2", 64'(hi), 64'(32'hDEAD_BEEF));
        op = MD_DIV; d1 = 32'd100; d2 = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("abort_no_commit", {hi, lo}, 64'(0));
        check("abort_idle", 64'(busy), 64'(0));

        @(negedge clk);
        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
